fft_frame_sched: RTL and testbench

Frame scheduler that shares one streaming `fft` pipeline between two sample sources (channel 0, channel 1). It arbitrates whole frames round-robin, drives the core's `ien`/`iaddr`/`iReal`/`iImag` with natural-order addresses, and keeps a channel-tag queue so results leaving the core carry their source channel and frame boundaries. It sits directly in front of `fft`, and its result side sits directly behind it.

---
 rtl/fft_sched_pkg.sv | 10 +
 rtl/fft_frame_sched_if.sv | 47 ++++
 rtl/fft_tag_fifo.sv | 45 ++++
 rtl/fft_frame_sched.sv | 201 ++++++++++++++++++++
 tb/tb_fft_frame_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_sched_pkg.sv
// rtl/fft_sched_pkg.sv - shared types and constants for the fft frame scheduler
package fft_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_PAD} state_t;

  typedef logic chan_t;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/fft_frame_sched_if.sv
// rtl/fft_frame_sched_if.sv - source, core and result signals of the fft frame scheduler
interface fft_frame_sched_if #(
  parameter int STAGES = 10,
  parameter int RW     = 16,
  parameter int IW     = 16
);

  logic              s0_valid, s0_ready, s0_sop;
  logic [RW-1:0]     s0_re;
  logic [IW-1:0]     s0_im;
  logic              s1_valid, s1_ready, s1_sop;
  logic [RW-1:0]     s1_re;
  logic [IW-1:0]     s1_im;

  logic              f_ien;
  logic [STAGES-1:0] f_iaddr;
  logic [RW-1:0]     f_ire;
  logic [IW-1:0]     f_iim;
  logic              f_oen;
  logic [RW-1:0]     f_ore;
  logic [IW-1:0]     f_oim;
  logic [STAGES-1:0] f_oaddr;

  logic              r_valid, r_chan, r_sop, r_eop;
  logic [STAGES-1:0] r_addr;
  logic [RW-1:0]     r_re;
  logic [IW-1:0]     r_im;

  modport master (
    input  s0_valid, s0_sop, s0_re, s0_im,
    input  s1_valid, s1_sop, s1_re, s1_im,
    input  f_oen, f_ore, f_oim, f_oaddr,
    output s0_ready, s1_ready,
    output f_ien, f_iaddr, f_ire, f_iim,
    output r_valid, r_chan, r_sop, r_eop, r_addr, r_re, r_im
  );

  modport slave (
    output s0_valid, s0_sop, s0_re, s0_im,
    output s1_valid, s1_sop, s1_re, s1_im,
    output f_oen, f_ore, f_oim, f_oaddr,
    input  s0_ready, s1_ready,
    input  f_ien, f_iaddr, f_ire, f_iim,
    input  r_valid, r_chan, r_sop, r_eop, r_addr, r_re, r_im
  );

endinterface

// File: rtl/fft_tag_fifo.sv
// rtl/fft_tag_fifo.sv - channel-tag FIFO, one entry per frame in flight in the core
module fft_tag_fifo
  import fft_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  chan_t din,
  input  logic  pop,
  output chan_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  chan_t         mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          do_push, do_pop;

  // A push into a full queue is allowed only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fft_frame_sched.sv
// rtl/fft_frame_sched.sv - two-channel frame scheduler in front of a streaming fft core
// Optional zero-padding of stalled frames: FFT_SCHED_PAD_EN.
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int STAGES    = 10,
  parameter int RW        = 16,
  parameter int IW        = 16,
  parameter int TAG_DEPTH = 4,
  parameter int PAD_TMO   = 64
) (
  input  logic               iclk,
  input  logic               rst,
  fft_frame_sched_if.master  bus,
  output logic               busy,
  output logic [15:0]        drop_cnt
);

  localparam logic [STAGES-1:0] LAST = '1;

  state_t            state, state_nxt;
  chan_t             gnt, last, gnt_nxt;
  logic [STAGES-1:0] cnt, frame_out;
  logic              req0, req1, grant, hs;
  logic              rdy0, rdy1;
  logic              g_valid, g_sop;
  logic [RW-1:0]     g_re;
  logic [IW-1:0]     g_im;
  logic              idle_drop0, idle_drop1, sop_err, oen_err;
  logic [1:0]        drop_inc;
  logic [16:0]       drop_sum;
  logic              tag_pop, tag_full, tag_empty;
  chan_t             tag_head;

  logic              f_ien_q;
  logic [STAGES-1:0] f_iaddr_q, r_addr_q;
  logic [RW-1:0]     f_ire_q, r_re_q;
  logic [IW-1:0]     f_iim_q, r_im_q;
  logic              r_valid_q, r_chan_q, r_sop_q, r_eop_q;

`ifdef FFT_SCHED_PAD_EN
  localparam int SW = $clog2(PAD_TMO + 1);
  logic [SW-1:0] stall_cnt;
`endif

  assign req0    = bus.s0_valid && bus.s0_sop;
  assign req1    = bus.s1_valid && bus.s1_sop;
  assign gnt_nxt = (req0 && req1) ? ~last : chan_t'(req1);
  assign g_valid = gnt ? bus.s1_valid : bus.s0_valid;
  assign g_sop   = gnt ? bus.s1_sop   : bus.s0_sop;
  assign g_re    = gnt ? bus.s1_re    : bus.s0_re;
  assign g_im    = gnt ? bus.s1_im    : bus.s0_im;

  always_ff @(posedge iclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    grant      = 1'b0;
    hs         = 1'b0;
    idle_drop0 = 1'b0;
    idle_drop1 = 1'b0;
    case (state)
      S_IDLE: begin
        // Stray mid-frame samples are swallowed so a misaligned source can resync.
        idle_drop0 = bus.s0_valid && !bus.s0_sop;
        idle_drop1 = bus.s1_valid && !bus.s1_sop;
        rdy0       = idle_drop0;
        rdy1       = idle_drop1;
        if ((req0 || req1) && !tag_full) begin
          grant     = 1'b1;
          state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        rdy0 = !gnt;
        rdy1 = gnt;
        hs   = g_valid;
        if (hs && cnt == LAST)
          state_nxt = S_IDLE;
`ifdef FFT_SCHED_PAD_EN
        else if (!g_valid && stall_cnt == SW'(PAD_TMO - 1))
          state_nxt = S_PAD;
`endif
      end
      S_PAD: begin
`ifdef FFT_SCHED_PAD_EN
        if (cnt == LAST) state_nxt = S_IDLE;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign sop_err  = hs && g_sop && (cnt != '0);
  assign oen_err  = bus.f_oen && tag_empty;
  assign drop_inc = 2'(idle_drop0) + 2'(idle_drop1) + 2'(sop_err) + 2'(oen_err);
  assign drop_sum = 17'(drop_cnt) + 17'(drop_inc);
  assign tag_pop  = bus.f_oen && (frame_out == LAST);

  always_ff @(posedge iclk) begin
    if (rst) begin
      gnt       <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      f_ien_q   <= 1'b0;
      f_iaddr_q <= '0;
      f_ire_q   <= '0;
      f_iim_q   <= '0;
      drop_cnt  <= '0;
    end else begin
      f_ien_q  <= 1'b0;
      drop_cnt <= (drop_sum > 17'(DROP_MAX)) ? DROP_MAX : drop_sum[15:0];
      if (grant) begin
        gnt  <= gnt_nxt;
        last <= gnt_nxt;
        cnt  <= '0;
      end
      if (hs) begin
        f_ien_q   <= 1'b1;
        f_iaddr_q <= cnt;
        f_ire_q   <= g_re;
        f_iim_q   <= g_im;
        cnt       <= cnt + 1'b1;
      end
      if (state == S_PAD) begin
        f_ien_q   <= 1'b1;
        f_iaddr_q <= cnt;
        f_ire_q   <= '0;
        f_iim_q   <= '0;
        cnt       <= cnt + 1'b1;
      end
    end
  end

`ifdef FFT_SCHED_PAD_EN
  always_ff @(posedge iclk) begin
    if (rst || grant || hs)
      stall_cnt <= '0;
    else if (state == S_XFER && !g_valid && stall_cnt != SW'(PAD_TMO))
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

  always_ff @(posedge iclk) begin
    if (rst) begin
      frame_out <= '0;
      r_valid_q <= 1'b0;
      r_chan_q  <= 1'b0;
      r_sop_q   <= 1'b0;
      r_eop_q   <= 1'b0;
      r_addr_q  <= '0;
      r_re_q    <= '0;
      r_im_q    <= '0;
    end else begin
      r_valid_q <= bus.f_oen;
      r_sop_q   <= bus.f_oen && (frame_out == '0);
      r_eop_q   <= tag_pop;
      if (bus.f_oen) begin
        frame_out <= frame_out + 1'b1;
        r_chan_q  <= tag_empty ? 1'b0 : tag_head;
        r_addr_q  <= bus.f_oaddr;
        r_re_q    <= bus.f_ore;
        r_im_q    <= bus.f_oim;
      end
    end
  end

  fft_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk   (iclk),
    .rst   (rst),
    .push  (grant),
    .din   (gnt_nxt),
    .pop   (tag_pop),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign busy         = (state != S_IDLE);
  assign bus.s0_ready = rdy0;
  assign bus.s1_ready = rdy1;
  assign bus.f_ien    = f_ien_q;
  assign bus.f_iaddr  = f_iaddr_q;
  assign bus.f_ire    = f_ire_q;
  assign bus.f_iim    = f_iim_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_chan   = r_chan_q;
  assign bus.r_sop    = r_sop_q;
  assign bus.r_eop    = r_eop_q;
  assign bus.r_addr   = r_addr_q;
  assign bus.r_re     = r_re_q;
  assign bus.r_im     = r_im_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb/tb_fft_frame_sched.sv - directed self-checking bench for fft_frame_sched
module tb_fft_frame_sched;

  localparam int STAGES    = 4;
  localparam int RW        = 16;
  localparam int IW        = 16;
  localparam int TAG_DEPTH = 4;
  localparam int PAD_TMO   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] drop_cnt;
  int          checks = 0;
  int          errors = 0;
  int          order[$];

  fft_frame_sched_if #(.STAGES(STAGES), .RW(RW), .IW(IW)) bus ();

  fft_frame_sched #(
    .STAGES(STAGES), .RW(RW), .IW(IW), .TAG_DEPTH(TAG_DEPTH), .PAD_TMO(PAD_TMO)
  ) dut (
    .iclk     (clk),
    .rst      (rst),
    .bus      (bus.master),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.s0_valid = 1'b0; bus.s0_sop = 1'b0; bus.s0_re = '0; bus.s0_im = '0;
    bus.s1_valid = 1'b0; bus.s1_sop = 1'b0; bus.s1_re = '0; bus.s1_im = '0;
    bus.f_oen = 1'b0; bus.f_ore = '0; bus.f_oim = '0; bus.f_oaddr = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drive(input bit ch, input logic v, input logic sop, input int val);
    if (ch) begin
      bus.s1_valid = v; bus.s1_sop = sop; bus.s1_re = 16'(val); bus.s1_im = 16'(val + 1000);
    end else begin
      bus.s0_valid = v; bus.s0_sop = sop; bus.s0_re = 16'(val); bus.s0_im = 16'(val + 1000);
    end
  endtask

  function automatic logic rdy(input bit ch);
    return ch ? bus.s1_ready : bus.s0_ready;
  endfunction

  task automatic send_frame(input bit ch, input int base, input int extra_sop, input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      drive(ch, 1'b1, (i == 0) || (i == extra_sop), base + i);
      #1;
      for (int w = 0; w < 20 && !rdy(ch); w++) begin
        step();
        #1;
      end
      checks++;
      if (rdy(ch) !== 1'b1) begin
        errors++;
        $display("FAIL frame_ready ch%0d sample %0d: ready %b, expected 1", ch, i, rdy(ch));
      end
      step();
      checks++;
      if (bus.f_ien !== 1'b1 || bus.f_iaddr !== 4'(i) || bus.f_ire !== 16'(base + i) ||
          bus.f_iim !== 16'(base + i + 1000)) begin
        errors++;
        $display("FAIL frame_fwd ch%0d sample %0d: ien %b addr %0d re %0h im %0h, expected 1 %0d %0h %0h",
                 ch, i, bus.f_ien, bus.f_iaddr, bus.f_ire, bus.f_iim, i, 16'(base + i), 16'(base + i + 1000));
      end
    end
    drive(ch, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset;
    idle_inputs();
    step();
    step();
    checks++;
    if (bus.f_ien !== 1'b0 || bus.f_iaddr !== '0 || bus.f_ire !== '0 || bus.f_iim !== '0) begin
      errors++;
      $display("FAIL reset_core_side: ien %b addr %0d re %0h im %0h, expected all 0",
               bus.f_ien, bus.f_iaddr, bus.f_ire, bus.f_iim);
    end
    checks++;
    if (bus.r_valid !== 1'b0 || bus.r_chan !== 1'b0 || bus.r_sop !== 1'b0 || bus.r_eop !== 1'b0 ||
        bus.r_addr !== '0 || bus.r_re !== '0 || bus.r_im !== '0) begin
      errors++;
      $display("FAIL reset_result_side: valid %b chan %b sop %b eop %b addr %0d, expected all 0",
               bus.r_valid, bus.r_chan, bus.r_sop, bus.r_eop, bus.r_addr);
    end
    checks++;
    if (busy !== 1'b0 || drop_cnt !== 16'd0 || bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy %b drop %0d rdy %b%b, expected 0 0 00",
               busy, drop_cnt, bus.s0_ready, bus.s1_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_frame;
    send_frame(1'b0, 100, -1, 16);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_after: busy %b, expected 0", busy);
    end
    step();
    checks++;
    if (bus.f_ien !== 1'b0 || bus.f_ire !== 16'd115) begin
      errors++;
      $display("FAIL single_hold: ien %b re %0d, expected 0 115", bus.f_ien, bus.f_ire);
    end
    for (int i = 0; i < 16; i++) begin
      bus.f_oen = 1'b1; bus.f_oaddr = 4'(i); bus.f_ore = 16'(i * 3); bus.f_oim = 16'(i + 50);
      step();
      checks++;
      if (bus.r_valid !== 1'b1 || bus.r_chan !== 1'b0 || bus.r_sop !== (i == 0) ||
          bus.r_eop !== (i == 15) || bus.r_addr !== 4'(i) || bus.r_re !== 16'(i * 3) ||
          bus.r_im !== 16'(i + 50)) begin
        errors++;
        $display("FAIL single_result beat %0d: valid %b chan %b sop %b eop %b addr %0d re %0d im %0d, expected 1 0 %b %b %0d %0d %0d",
                 i, bus.r_valid, bus.r_chan, bus.r_sop, bus.r_eop, bus.r_addr, bus.r_re, bus.r_im,
                 i == 0, i == 15, i, i * 3, i + 50);
      end
    end
    bus.f_oen = 1'b0;
    step();
    checks++;
    if (bus.r_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_result_end: r_valid %b, expected 0", bus.r_valid);
    end
  endtask

  task automatic test_round_robin;
    int idx[2];
    int hs_total;
    int both;
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    do_reset();
    idx = '{0, 0};
    hs_total = 0;
    both = 0;
    order.delete();
    for (int c = 0; c < 300 && hs_total < 64; c++) begin
      drive(1'b0, 1'b1, idx[0] == 0, 200 + idx[0]);
      drive(1'b1, 1'b1, idx[1] == 0, 300 + idx[1]);
      #1;
      if (bus.s0_ready && bus.s1_ready) both++;
      for (int ch = 0; ch < 2; ch++) begin
        if (rdy(ch[0])) begin
          if (idx[ch] == 0) order.push_back(ch);
          idx[ch] = (idx[ch] + 1) % 16;
          hs_total++;
        end
      end
      step();
    end
    checks++;
    if (hs_total !== 64) begin
      errors++;
      $display("FAIL rr_handshakes: %0d, expected 64", hs_total);
    end
    checks++;
    if (both !== 0) begin
      errors++;
      $display("FAIL rr_both_ready: %0d cycles, expected 0", both);
    end
    checks++;
    if (order.size() !== 4) begin
      errors++;
      $display("FAIL rr_grant_count: %0d, expected 4", order.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (order[g] !== exp_order[g]) begin
          errors++;
          $display("FAIL rr_grant %0d: chan %0d, expected %0d", g, order[g], exp_order[g]);
        end
      end
    end
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rr_drop: %0d, expected 0", drop_cnt);
    end
  endtask

  task automatic test_tag_full;
    int exp_chan[4];
    exp_chan = '{0, 1, 0, 1};
    drive(1'b0, 1'b1, 1'b1, 250);
    drive(1'b1, 1'b1, 1'b1, 350);
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL full_block cycle %0d: rdy %b%b busy %b, expected 00 0",
                 c, bus.s0_ready, bus.s1_ready, busy);
      end
      step();
    end
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 16; j++) begin
        bus.f_oen = 1'b1; bus.f_oaddr = 4'(j); bus.f_ore = 16'(f * 16 + j); bus.f_oim = 16'(j);
        #1;
        if (f == 0) begin
          checks++;
          if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_drain_block beat %0d: rdy %b%b, expected 00", j, bus.s0_ready, bus.s1_ready);
          end
        end
        step();
        if (j == 15) begin
          checks++;
          if (bus.r_eop !== 1'b1 || bus.r_chan !== exp_chan[f][0]) begin
            errors++;
            $display("FAIL full_tag frame %0d: eop %b chan %b, expected 1 %0d",
                     f, bus.r_eop, bus.r_chan, exp_chan[f]);
          end
        end
      end
      bus.f_oen = 1'b0;
      if (f == 0) begin
        #1;
        checks++;
        if (bus.s0_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_grant_early: s0_ready %b, expected 0", bus.s0_ready);
        end
        step();
        #1;
        checks++;
        if (bus.s0_ready !== 1'b1 || bus.s1_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_grant_after_pop: rdy %b%b, expected s0=1 s1=0", bus.s0_ready, bus.s1_ready);
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 0);
        step();
      end
    end
  endtask

  task automatic test_idle_drop;
    int ien_seen;
    do_reset();
    ien_seen = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 700 + i);
      #1;
      checks++;
      if (bus.s1_ready !== 1'b1) begin
        errors++;
        $display("FAIL drop_ready sample %0d: s1_ready %b, expected 1", i, bus.s1_ready);
      end
      step();
      if (bus.f_ien) ien_seen++;
    end
    drive(1'b1, 1'b0, 1'b0, 0);
    step();
    if (bus.f_ien) ien_seen++;
    checks++;
    if (drop_cnt !== 16'd3 || ien_seen !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_count: drop %0d ien pulses %0d busy %b, expected 3 0 0", drop_cnt, ien_seen, busy);
    end
  endtask

  task automatic test_mid_frame_sop;
    send_frame(1'b0, 800, 5, 16);
    checks++;
    if (drop_cnt !== 16'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_sop: drop %0d busy %b, expected 4 0", drop_cnt, busy);
    end
  endtask

  task automatic test_empty_tag;
    do_reset();
    bus.f_oen = 1'b1; bus.f_oaddr = 4'd9; bus.f_ore = 16'd77; bus.f_oim = 16'd88;
    step();
    bus.f_oen = 1'b0;
    checks++;
    if (bus.r_valid !== 1'b1 || bus.r_chan !== 1'b0 || bus.r_sop !== 1'b1 || bus.r_addr !== 4'd9 ||
        bus.r_re !== 16'd77 || bus.r_im !== 16'd88 || drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL empty_tag: valid %b chan %b sop %b addr %0d re %0d im %0d drop %0d, expected 1 0 1 9 77 88 1",
               bus.r_valid, bus.r_chan, bus.r_sop, bus.r_addr, bus.r_re, bus.r_im, drop_cnt);
    end
  endtask

  task automatic test_reset_mid_frame;
    do_reset();
    send_frame(1'b0, 400, -1, 7);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy_before: busy %b, expected 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.f_ien !== 1'b0 || bus.f_iaddr !== '0 || bus.f_ire !== '0 || busy !== 1'b0 ||
        bus.r_valid !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid: ien %b addr %0d re %0h busy %b rvalid %b drop %0d, expected all 0",
               bus.f_ien, bus.f_iaddr, bus.f_ire, busy, bus.r_valid, drop_cnt);
    end
    send_frame(1'b0, 500, -1, 16);
  endtask

  task automatic test_pad;
`ifdef FFT_SCHED_PAD_EN
    int k;
    int first;
    do_reset();
    send_frame(1'b0, 600, -1, 5);
    k = 0;
    first = -1;
    for (int c = 1; c <= 40 && k < 11; c++) begin
      step();
      if (bus.f_ien) begin
        if (first < 0) first = c;
        checks++;
        if (bus.f_iaddr !== 4'(5 + k) || bus.f_ire !== '0 || bus.f_iim !== '0) begin
          errors++;
          $display("FAIL pad_sample %0d: addr %0d re %0h im %0h, expected %0d 0 0",
                   k, bus.f_iaddr, bus.f_ire, bus.f_iim, 5 + k);
        end
        k++;
      end
    end
    checks++;
    if (k !== 11 || first !== 9 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pad_summary: samples %0d first at %0d busy %b, expected 11 9 0", k, first, busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_tag_full();
    test_idle_drop();
    test_mid_frame_sop();
    test_empty_tag();
    test_reset_mid_frame();
    test_pad();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
